// File: rtl/fpu_unpack_prenorm_pkg.sv
// Shared definitions for the FPU operand unpack / pre-normalization stage.
package fpu_defs;

  // Default field widths (IEEE-754 single precision).
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  // Operand class flags, carried alongside the unpacked fields.
  typedef struct packed {
    logic zero;
    logic denormal;
    logic inf;
    logic nan;
    logic snan;
  } fpu_class_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fpu_prenorm_state_e;

endpackage

// File: rtl/fpu_unpack_prenorm_lzc_window.sv
// Leading-zero count over a small window, plus an all-zero indication.
// The count is only meaningful when all_zero_o is low.
module fpu_lzc_window #(
  parameter int WIDTH = 4,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] win_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             all_zero_o
);

  // seen[i] is set when any bit at or above position i is one.
  logic [WIDTH-1:0] seen;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_seen
      assign seen[gi] = |win_i[WIDTH-1:gi];
    end
  endgenerate

  // Leading zeros are exactly the positions with nothing set above them.
  always_comb begin
    int zeros;
    zeros = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!seen[i]) zeros = zeros + 1;
    end
    cnt_o      = CNT_W'(zeros);
    all_zero_o = ~seen[0];
  end

endmodule

// File: rtl/fpu_unpack_prenorm.sv
// Operand unpack and pre-normalization: splits a packed float into sign,
// exponent and explicit-leading-bit mantissa, classifies it, and walks
// denormals left a window at a time until the mantissa MSB is one.
module fpu_unpack_prenorm
  import fpu_defs::*;
#(
  parameter int EXP_W      = FP_EXP_W,
  parameter int MANT_W     = FP_MANT_W,
  parameter int SHIFT_STEP = 4
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RI,
  input  logic [EXP_W+MANT_W:0]   Op_DI,
  input  logic                    In_valid_SI,
  output logic                    In_ready_SO,
  output logic                    Sign_DO,
  output logic signed [EXP_W+1:0] Exp_DO,
  output logic [MANT_W:0]         Mant_DO,
  output logic                    Zero_SO,
  output logic                    Denormal_SO,
  output logic                    Inf_SO,
  output logic                    NaN_SO,
  output logic                    SNaN_SO,
  output logic                    Out_valid_SO,
  input  logic                    Out_ready_SI
);

  localparam int CNT_W = (SHIFT_STEP > 1) ? $clog2(SHIFT_STEP) : 1;
  localparam logic signed [EXP_W+1:0] STEP_EXP = (EXP_W+2)'(SHIFT_STEP);

  fpu_prenorm_state_e state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic [MANT_W:0]         mant_q, mant_d;
  fpu_class_t              cls_q, cls_d;

  // Decoded view of the incoming operand, ready to be loaded.
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [MANT_W-1:0]       in_frac;
  logic                    e_zero, e_ones, f_zero;
  fpu_class_t              load_cls;
  logic signed [EXP_W+1:0] load_exp;
  logic [MANT_W:0]         load_mant;
  fpu_prenorm_state_e      load_state;

  logic                    accept;
  logic [CNT_W-1:0]        lz_cnt;
  logic                    lz_all_zero;
  logic signed [EXP_W+1:0] lz_cnt_ext;

  // Field split and classification of the operand on the input port.
  always_comb begin
    in_sign = Op_DI[EXP_W+MANT_W];
    in_exp  = Op_DI[MANT_W +: EXP_W];
    in_frac = Op_DI[MANT_W-1:0];
    e_zero  = ~|in_exp;
    e_ones  = &in_exp;
    f_zero  = ~|in_frac;

    load_cls          = '0;
    load_cls.zero     = e_zero & f_zero;
    load_cls.denormal = e_zero & ~f_zero;
    load_cls.inf      = e_ones & f_zero;
    load_cls.nan      = e_ones & ~f_zero;
    // Quiet bit clear on a NaN marks it signalling.
    load_cls.snan     = e_ones & ~f_zero & ~in_frac[MANT_W-1];

    if (load_cls.zero) begin
      load_mant = '0;
      load_exp  = '0;
    end else if (load_cls.denormal) begin
      // Denormals share the minimum normal exponent (1); shifting subtracts.
      load_mant = {1'b0, in_frac};
      load_exp  = (EXP_W+2)'(1);
    end else begin
      load_mant = {1'b1, in_frac};
      load_exp  = {2'b00, in_exp};
    end

    load_state = load_cls.denormal ? ST_SHIFT : ST_DONE;
  end

  // The shift window is the top SHIFT_STEP bits of the mantissa.
  fpu_lzc_window #(
    .WIDTH (SHIFT_STEP),
    .CNT_W (CNT_W)
  ) u_lzc (
    .win_i      (mant_q[MANT_W -: SHIFT_STEP]),
    .cnt_o      (lz_cnt),
    .all_zero_o (lz_all_zero)
  );

  assign lz_cnt_ext = {{(EXP_W+2-CNT_W){1'b0}}, lz_cnt};

  // Handshake outputs follow directly from the state.
  always_comb begin
    In_ready_SO = 1'b0;
    case (state_q)
      ST_IDLE:  In_ready_SO = 1'b1;
      ST_DONE:  In_ready_SO = Out_ready_SI;
      default:  In_ready_SO = 1'b0;
    endcase
  end

  assign accept       = In_valid_SI & In_ready_SO;
  assign Out_valid_SO = (state_q == ST_DONE);

  // Next-state and datapath update; registers hold unless loaded or shifting.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    cls_d   = cls_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = load_state;
          sign_d  = in_sign;
          exp_d   = load_exp;
          mant_d  = load_mant;
          cls_d   = load_cls;
        end
      end

      ST_SHIFT: begin
        if (lz_all_zero) begin
          mant_d = mant_q << SHIFT_STEP;
          exp_d  = exp_q - STEP_EXP;
        end else begin
          mant_d  = mant_q << lz_cnt;
          exp_d   = exp_q - lz_cnt_ext;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (Out_ready_SI) begin
          if (accept) begin
            state_d = load_state;
            sign_d  = in_sign;
            exp_d   = load_exp;
            mant_d  = load_mant;
            cls_d   = load_cls;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      cls_q   <= cls_d;
    end
  end

  assign Sign_DO     = sign_q;
  assign Exp_DO      = exp_q;
  assign Mant_DO     = mant_q;
  assign Zero_SO     = cls_q.zero;
  assign Denormal_SO = cls_q.denormal;
  assign Inf_SO      = cls_q.inf;
  assign NaN_SO      = cls_q.nan;
  assign SNaN_SO     = cls_q.snan;

endmodule

// File: tb/tb_fpu_unpack_prenorm.sv
// Scoreboard bench for fpu_unpack_prenorm with directed single-precision vectors.
module tb_fpu_unpack_prenorm;

  logic        Clk_CI = 1'b0;
  logic        Rst_RI;
  logic [31:0] Op_DI;
  logic        In_valid_SI;
  logic        In_ready_SO;
  logic        Sign_DO;
  logic signed [9:0] Exp_DO;
  logic [23:0] Mant_DO;
  logic        Zero_SO, Denormal_SO, Inf_SO, NaN_SO, SNaN_SO;
  logic        Out_valid_SO;
  logic        Out_ready_SI;

  fpu_unpack_prenorm #(
    .EXP_W      (8),
    .MANT_W     (23),
    .SHIFT_STEP (4)
  ) dut (
    .Clk_CI       (Clk_CI),
    .Rst_RI       (Rst_RI),
    .Op_DI        (Op_DI),
    .In_valid_SI  (In_valid_SI),
    .In_ready_SO  (In_ready_SO),
    .Sign_DO      (Sign_DO),
    .Exp_DO       (Exp_DO),
    .Mant_DO      (Mant_DO),
    .Zero_SO      (Zero_SO),
    .Denormal_SO  (Denormal_SO),
    .Inf_SO       (Inf_SO),
    .NaN_SO       (NaN_SO),
    .SNaN_SO      (SNaN_SO),
    .Out_valid_SO (Out_valid_SO),
    .Out_ready_SI (Out_ready_SI)
  );

  always #5 Clk_CI = ~Clk_CI;

  // Flag vector order: {zero, denormal, inf, nan, snan}
  typedef struct {
    logic [31:0] op;
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic [4:0]  flags;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge Clk_CI) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] op, input logic s, input logic [9:0] e,
                              input logic [23:0] m, input logic [4:0] f, input int lat);
    exp_t x;
    x.op = op; x.sign = s; x.exp = e; x.mant = m; x.flags = f; x.lat = lat; x.acc_cyc = 0;
    return x;
  endfunction

  // Monitor: samples mid-cycle, records first-valid cycle, pops on handshake.
  initial begin
    bit first_pending;
    int first_cyc;
    exp_t x;
    first_pending = 1'b1;
    first_cyc = 0;
    forever begin
      @(negedge Clk_CI);
      #2;
      if (Rst_RI) begin
        first_pending = 1'b1;
      end else begin
        if (Out_valid_SO && first_pending) begin
          first_cyc = cyc;
          first_pending = 1'b0;
        end
        if (Out_valid_SO && Out_ready_SI) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            x = sb.pop_front();
            chk("sign", {31'd0, Sign_DO}, {31'd0, x.sign});
            chk("exp", {22'd0, Exp_DO}, {22'd0, x.exp});
            chk("mant", {8'd0, Mant_DO}, {8'd0, x.mant});
            chk("flags", {27'd0, Zero_SO, Denormal_SO, Inf_SO, NaN_SO, SNaN_SO}, {27'd0, x.flags});
            chk("latency", first_cyc - x.acc_cyc, x.lat);
            $display("txn op=0x%08h sign=%0d exp=%0d mant=0x%06h flags=%05b lat=%0d",
                     x.op, Sign_DO, Exp_DO, Mant_DO,
                     {Zero_SO, Denormal_SO, Inf_SO, NaN_SO, SNaN_SO}, first_cyc - x.acc_cyc);
          end
          first_pending = 1'b1;
        end
      end
    end
  end

  // Present an operand at a falling edge; hold until accepted.
  task automatic send(input exp_t x, input bit push);
    int tries;
    tries = 0;
    Op_DI = x.op;
    In_valid_SI = 1'b1;
    #1;
    while (!In_ready_SO && tries < 100) begin
      @(negedge Clk_CI);
      #1;
      tries++;
    end
    if (!In_ready_SO) chk("accept_timeout", 32'd0, 32'd1);
    x.acc_cyc = cyc;
    if (push) sb.push_back(x);
    @(negedge Clk_CI);
    In_valid_SI = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge Clk_CI);
      n++;
    end
    @(negedge Clk_CI);
    @(negedge Clk_CI);
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t v;
    Rst_RI = 1'b1;
    In_valid_SI = 1'b0;
    Out_ready_SI = 1'b1;
    Op_DI = 32'd0;
    repeat (3) @(negedge Clk_CI);
    #1;
    chk("rst_out_valid", {31'd0, Out_valid_SO}, 32'd0);
    chk("rst_in_ready", {31'd0, In_ready_SO}, 32'd1);
    chk("rst_exp", {22'd0, Exp_DO}, 32'd0);
    chk("rst_mant", {8'd0, Mant_DO}, 32'd0);
    chk("rst_flags", {26'd0, Sign_DO, Zero_SO, Denormal_SO, Inf_SO, NaN_SO, SNaN_SO}, 32'd0);
    @(negedge Clk_CI);
    Rst_RI = 1'b0;
    @(negedge Clk_CI);

    // Directed single vectors, each drained before the next.
    send(mk(32'h3F800000, 1'b0, 10'd127,  24'h800000, 5'b00000, 1), 1'b1); drain();
    send(mk(32'h00000001, 1'b0, 10'h3EA,  24'h800000, 5'b01000, 7), 1'b1); drain();
    send(mk(32'h80400000, 1'b1, 10'd0,    24'h800000, 5'b01000, 2), 1'b1); drain();
    send(mk(32'h00080000, 1'b0, 10'h3FD,  24'h800000, 5'b01000, 3), 1'b1); drain();
    send(mk(32'h7FC00000, 1'b0, 10'd255,  24'hC00000, 5'b00010, 1), 1'b1); drain();
    send(mk(32'h7F800001, 1'b0, 10'd255,  24'h800001, 5'b00011, 1), 1'b1); drain();
    send(mk(32'hFF800000, 1'b1, 10'd255,  24'h800000, 5'b00100, 1), 1'b1); drain();
    send(mk(32'h00000000, 1'b0, 10'd0,    24'h000000, 5'b10000, 1), 1'b1); drain();
    send(mk(32'h7F7FFFFF, 1'b0, 10'd254,  24'hFFFFFF, 5'b00000, 1), 1'b1); drain();

    // Backpressure: result must sit unchanged while downstream stalls.
    Out_ready_SI = 1'b0;
    send(mk(32'h40490FDB, 1'b0, 10'd128, 24'hC90FDB, 5'b00000, 1), 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", {31'd0, Out_valid_SO}, 32'd1);
      chk("stall_in_ready", {31'd0, In_ready_SO}, 32'd0);
      chk("stall_exp", {22'd0, Exp_DO}, 32'd128);
      chk("stall_mant", {8'd0, Mant_DO}, 32'h00C90FDB);
      @(negedge Clk_CI);
    end
    Out_ready_SI = 1'b1;

    // Back-to-back stream of normals.
    send(mk(32'h40000000, 1'b0, 10'd128, 24'h800000, 5'b00000, 1), 1'b1);
    send(mk(32'hC0400000, 1'b1, 10'd128, 24'hC00000, 5'b00000, 1), 1'b1);
    send(mk(32'h3F000000, 1'b0, 10'd126, 24'h800000, 5'b00000, 1), 1'b1);
    send(mk(32'h00800000, 1'b0, 10'd1,   24'h800000, 5'b00000, 1), 1'b1);
    drain();

    // Reset in the third SHIFT cycle of the smallest denormal.
    v = mk(32'h00000001, 1'b0, 10'h3EA, 24'h800000, 5'b01000, 7);
    send(v, 1'b0);
    #1;
    chk("shift_in_ready", {31'd0, In_ready_SO}, 32'd0);
    @(negedge Clk_CI);
    @(negedge Clk_CI);
    Rst_RI = 1'b1;
    @(negedge Clk_CI);
    Rst_RI = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, Out_valid_SO}, 32'd0);
    chk("midrst_in_ready", {31'd0, In_ready_SO}, 32'd1);
    chk("midrst_mant", {8'd0, Mant_DO}, 32'd0);
    chk("midrst_flags", {27'd0, Zero_SO, Denormal_SO, Inf_SO, NaN_SO, SNaN_SO}, 32'd0);
    @(negedge Clk_CI);
    send(mk(32'h40000000, 1'b0, 10'd128, 24'h800000, 5'b00000, 1), 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
